// File: rtl/park_space_allocator.sv
`default_nettype none
// ============================================================================
// Module   : park_space_allocator
// Purpose  : Allocates parking spaces to arriving cars. Each request gets the
//            highest-index free space, which is reserved only once the entry
//            gate confirms it. Exits free their space again. Bad exits are
//            flagged, and entries into a full lot are rejected.
// Ports    : clk          - clock, all state changes on its rising edge
//            reset        - asynchronous active-high reset
//            car_in       - entry request, held until granted or withdrawn
//            gate_ack     - gate confirms the car took the granted space
//            car_out      - single-cycle exit event
//            exit_number  - space index freed by car_out
//            grant_valid  - park_number valid, awaiting gate_ack
//            park_number  - granted space index (0 when no grant)
//            full_reject  - one-cycle pulse, no space free
//            exit_err     - one-cycle pulse, exit named free/out-of-range space
//            free_map     - bit i high means space i is free
//            free_count   - number of free spaces
//            entry_total  - accepted entries (PARK_SPACE_STATS_EN only)
//            reject_total - full rejections (PARK_SPACE_STATS_EN only)
// Options  : define PARK_SPACE_STATS_EN to add the 16-bit statistic counters
// Revision : 1.0 - initial release
// ============================================================================
module park_space_allocator #(
    parameter int NUM_SPACES = 8,
    parameter int IDX_W      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  car_in,
    input  logic                  gate_ack,
    input  logic                  car_out,
    input  logic [IDX_W-1:0]      exit_number,
    output logic                  grant_valid,
    output logic [IDX_W-1:0]      park_number,
    output logic                  full_reject,
    output logic                  exit_err,
    output logic [NUM_SPACES-1:0] free_map,
    output logic [IDX_W:0]        free_count
`ifdef PARK_SPACE_STATS_EN
    ,
    output logic [15:0]           entry_total,
    output logic [15:0]           reject_total
`endif
);

    localparam int           c_pad_w      = 2 ** IDX_W;
    localparam logic [IDX_W:0] c_num_spaces = (IDX_W + 1)'(NUM_SPACES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        GRANT  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                  w_take;
    logic                  w_reject;
    logic                  w_accept;
    logic                  w_any_free;
    logic [IDX_W-1:0]      w_high_idx;
    logic                  w_exit_in_range;
    logic                  w_exit_ok;
    logic                  w_exit_bad;
    logic [c_pad_w-1:0]    w_free_pad;
    logic [c_pad_w-1:0]    w_pad_next;
    logic [NUM_SPACES-1:0] w_free_next;

    // Zero-padded view of the map lets any IDX_W-wide index address it safely.
    // Padding bits read as "occupied" but are always masked by the range check.
    assign w_free_pad = c_pad_w'(free_map);
    assign w_any_free = |free_map;

    // Highest-index free space: later iterations override earlier ones.
    always_comb begin
        w_high_idx = '0;
        for (int i = 0; i < NUM_SPACES; i++) begin
            if (free_map[i]) begin
                w_high_idx = IDX_W'(i);
            end
        end
    end

    assign w_accept        = (r_state == GRANT) && gate_ack;
    assign w_exit_in_range = ({1'b0, exit_number} < c_num_spaces);
    assign w_exit_ok       = car_out && w_exit_in_range && !w_free_pad[exit_number];
    assign w_exit_bad      = car_out && !w_exit_ok;

    // Acceptance and a valid exit can never target the same bit: the granted
    // space is free, a valid exit names an occupied one.
    always_comb begin
        w_pad_next = w_free_pad;
        if (w_accept) begin
            w_pad_next[park_number] = 1'b0;
        end
        if (w_exit_ok) begin
            w_pad_next[exit_number] = 1'b1;
        end
        w_free_next = w_pad_next[NUM_SPACES-1:0];
    end

    always_comb begin
        w_state_next = r_state;
        w_take       = 1'b0;
        w_reject     = 1'b0;
        case (r_state)
            IDLE: begin
                if (car_in) begin
                    w_state_next = SEARCH;
                end
            end
            SEARCH: begin
                if (w_any_free) begin
                    w_take       = 1'b1;
                    w_state_next = GRANT;
                end else begin
                    w_reject     = 1'b1;
                    w_state_next = IDLE;
                end
            end
            GRANT: begin
                if (gate_ack || !car_in) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            grant_valid <= 1'b0;
            park_number <= '0;
            full_reject <= 1'b0;
            exit_err    <= 1'b0;
            free_map    <= '1;
            free_count  <= c_num_spaces;
        end else begin
            r_state     <= w_state_next;
            grant_valid <= (w_state_next == GRANT);
            if (w_take) begin
                park_number <= w_high_idx;
            end else if (w_state_next != GRANT) begin
                park_number <= '0;
            end
            full_reject <= w_reject;
            exit_err    <= w_exit_bad;
            free_map    <= w_free_next;
            free_count  <= free_count - (IDX_W + 1)'(w_accept) + (IDX_W + 1)'(w_exit_ok);
        end
    end

`ifdef PARK_SPACE_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_total  <= '0;
            reject_total <= '0;
        end else begin
            if (w_accept) begin
                entry_total <= entry_total + 16'd1;
            end
            if (w_reject) begin
                reject_total <= reject_total + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_park_space_allocator.sv
`default_nettype none
// ============================================================================
// Module   : tb_park_space_allocator
// Purpose  : Directed self-checking bench for park_space_allocator
// Revision : 1.0 - initial release
// ============================================================================
module tb_park_space_allocator;

    logic       clk;
    logic       reset;
    logic       car_in;
    logic       gate_ack;
    logic       car_out;
    logic [2:0] exit_number;
    logic       grant_valid;
    logic [2:0] park_number;
    logic       full_reject;
    logic       exit_err;
    logic [7:0] free_map;
    logic [3:0] free_count;
`ifdef PARK_SPACE_STATS_EN
    logic [15:0] entry_total;
    logic [15:0] reject_total;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    park_space_allocator #(
        .NUM_SPACES(8),
        .IDX_W     (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .car_in      (car_in),
        .gate_ack    (gate_ack),
        .car_out     (car_out),
        .exit_number (exit_number),
        .grant_valid (grant_valid),
        .park_number (park_number),
        .full_reject (full_reject),
        .exit_err    (exit_err),
        .free_map    (free_map),
        .free_count  (free_count)
`ifdef PARK_SPACE_STATS_EN
        ,
        .entry_total (entry_total),
        .reject_total(reject_total)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full entry handshake expecting space exp_idx.
    task automatic enter(input logic [2:0] exp_idx);
        car_in = 1'b1;
        step();
        chk("gv_low_in_search", grant_valid, 1'b0);
        step();
        chk("gv_after_2", grant_valid, 1'b1);
        chk("park_idx", park_number, exp_idx);
        gate_ack = 1'b1;
        step();
        car_in   = 1'b0;
        gate_ack = 1'b0;
        chk("gv_drop", grant_valid, 1'b0);
        chk("park_zero", park_number, 3'd0);
    endtask

    task automatic exit_car(input logic [2:0] idx);
        car_out     = 1'b1;
        exit_number = idx;
        step();
        car_out = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        car_in      = 1'b0;
        gate_ack    = 1'b0;
        car_out     = 1'b0;
        exit_number = 3'd0;
        #23;
        chk("rst_gv", grant_valid, 1'b0);
        chk("rst_park", park_number, 3'd0);
        chk("rst_map", free_map, 8'hFF);
        chk("rst_cnt", free_count, 4'd8);
        chk("rst_rej", full_reject, 1'b0);
        chk("rst_err", exit_err, 1'b0);
        reset = 1'b0;
        step();

        // First entry gets the top space.
        enter(3'd7);
        chk("e1_map", free_map, 8'h7F);
        chk("e1_cnt", free_count, 4'd7);

        // Fill the lot.
        for (int i = 6; i >= 0; i--) begin
            enter(3'(i));
        end
        chk("full_map", free_map, 8'h00);
        chk("full_cnt", free_count, 4'd0);

        // Entry into a full lot.
        car_in = 1'b1;
        step();
        step();
        chk("rej_pulse", full_reject, 1'b1);
        chk("rej_gv", grant_valid, 1'b0);
        car_in = 1'b0;
        step();
        chk("rej_one_cycle", full_reject, 1'b0);
        chk("rej_map", free_map, 8'h00);

        // Exit from space 3 then re-enter.
        exit_car(3'd3);
        chk("x3_cnt", free_count, 4'd1);
        chk("x3_map", free_map, 8'h08);
        chk("x3_err", exit_err, 1'b0);
        enter(3'd3);
        chk("x3_reuse_cnt", free_count, 4'd0);

        // Exit of an already free space.
        exit_car(3'd5);
        chk("x5_map", free_map, 8'h20);
        exit_car(3'd5);
        chk("x5_err", exit_err, 1'b1);
        chk("x5_map_same", free_map, 8'h20);
        chk("x5_cnt_same", free_count, 4'd1);
        step();
        chk("x5_err_pulse", exit_err, 1'b0);

        // Acceptance of 6 with exit of 2 on the same edge.
        exit_car(3'd6);
        chk("x6_map", free_map, 8'h60);
        car_in = 1'b1;
        step();
        step();
        chk("g6_park", park_number, 3'd6);
        gate_ack    = 1'b1;
        car_out     = 1'b1;
        exit_number = 3'd2;
        step();
        car_in   = 1'b0;
        gate_ack = 1'b0;
        car_out  = 1'b0;
        chk("same_map", free_map, 8'h24);
        chk("same_cnt", free_count, 4'd2);

        // Withdrawal leaves the map untouched.
        car_in = 1'b1;
        step();
        step();
        chk("wd_park", park_number, 3'd5);
        car_in = 1'b0;
        step();
        chk("wd_gv", grant_valid, 1'b0);
        chk("wd_park0", park_number, 3'd0);
        chk("wd_map", free_map, 8'h24);

        // Exit naming the granted index while accepting it.
        car_in = 1'b1;
        step();
        step();
        chk("gx_park", park_number, 3'd5);
        gate_ack    = 1'b1;
        car_out     = 1'b1;
        exit_number = 3'd5;
        step();
        car_in   = 1'b0;
        gate_ack = 1'b0;
        car_out  = 1'b0;
        chk("gx_err", exit_err, 1'b1);
        chk("gx_map", free_map, 8'h04);
        chk("gx_cnt", free_count, 4'd1);

`ifdef PARK_SPACE_STATS_EN
        chk("stat_entry", entry_total, 16'd11);
        chk("stat_reject", reject_total, 16'd1);
`endif

        // Reset in the middle of a grant.
        car_in = 1'b1;
        step();
        step();
        chk("mr_gv", grant_valid, 1'b1);
        chk("mr_park", park_number, 3'd2);
        #1;
        reset = 1'b1;
        #1;
        chk("mr_async_gv", grant_valid, 1'b0);
        chk("mr_async_map", free_map, 8'hFF);
        car_in = 1'b0;
        #1;
        reset = 1'b0;
        step();
        chk("mr_gv_after", grant_valid, 1'b0);
        chk("mr_map_after", free_map, 8'hFF);
        chk("mr_cnt_after", free_count, 4'd8);
        chk("mr_park_after", park_number, 3'd0);
`ifdef PARK_SPACE_STATS_EN
        chk("mr_entry_total", entry_total, 16'd0);
        chk("mr_reject_total", reject_total, 16'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
